// File: rtl/sa_pkg.sv
// Shared types and helpers for the systolic-array sequencer.
// Holds the operand lane width, the sequencer state encoding and a
// ceil-log2 helper used to size the drain down-counter.
package sa_pkg;

    localparam int DW = 64;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CLEAR   = 3'd1,
        ST_PRELOAD = 3'd2,
        ST_FEED    = 3'd3,
        ST_DRAIN   = 3'd4,
        ST_DONE    = 3'd5
    } sa_state_e;

    // Smallest w such that 2**w >= value (returns 1 for value <= 2).
    function automatic int clog2(input int value);
        int w;
        w = 1;
        for (int i = 1; i < 31; i++) begin
            if ((32'sd1 << i) < value) begin
                w = i + 1;
            end else begin
                w = w;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/sa_skew_line.sv
// One diagonal-skew delay line: DEPTH register stages carrying a data word
// and its valid bit. The output is forced to zero whenever the last stage
// holds a bubble, so the array never accumulates stale buffer contents.
module sa_skew_line
    import sa_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] data_i,
    input  logic          valid_i,
    output logic [DW-1:0] data_o
);

    logic [DW-1:0]    data_q [DEPTH];
    logic [DEPTH-1:0] valid_q;

    // Shift data and valid one stage per clock; everything clears on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
            end
            valid_q <= '0;
        end else begin
            data_q[0]  <= data_i;
            valid_q[0] <= valid_i;
            for (int i = 1; i < DEPTH; i++) begin
                data_q[i]  <= data_q[i-1];
                valid_q[i] <= valid_q[i-1];
            end
        end
    end

    // Drive zero for bubbles so they contribute nothing to the MACs.
    always_comb begin
        if (valid_q[DEPTH-1]) begin
            data_o = data_q[DEPTH-1];
        end else begin
            data_o = '0;
        end
    end

endmodule

// File: rtl/sa_array_ctrl.sv
// Sequencer for an MxN systolic array. Accepts a start with inner
// dimension K, clears the accumulators, optionally strobes a weight
// preload, streams K operand vectors out of the A/B buffers, skews them
// diagonally onto the array edges, waits out the pipeline and pulses done.
// Control outputs are registered from the next-state value so they line up
// with the state they describe.
// Optional feature macro: SA_ARRAY_CTRL_PERF_EN adds a saturating
// busy-cycle counter on output perf_cycles.
module sa_array_ctrl
    import sa_pkg::*;
#(
    parameter int M   = 3,
    parameter int N   = 3,
    parameter int K_W = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [K_W-1:0]  k_len,
    input  logic            mode_os,
    output logic            busy,
    output logic            done,
    output logic            rd_en,
    output logic [K_W-1:0]  rd_idx,
    input  logic [DW*M-1:0] a_rd_data,
    input  logic [DW*N-1:0] b_rd_data,
    output logic [DW*M-1:0] sa_in_left,
    output logic [DW*N-1:0] sa_in_top,
    output logic            sa_clear,
    output logic            sa_output_stationary,
    output logic            sa_preload_valid
`ifdef SA_ARRAY_CTRL_PERF_EN
    ,
    output logic [31:0]     perf_cycles
`endif
);

    localparam int                DRN_W    = clog2(M + N + 1);
    localparam logic [DRN_W-1:0]  DRN_LOAD = DRN_W'(M + N - 1);

    sa_state_e        state_q, state_d;
    logic [K_W-1:0]   k_len_q, k_len_d;
    logic             mode_q, mode_d;
    logic [K_W-1:0]   rd_idx_q, rd_idx_d;
    logic [DRN_W-1:0] drn_q, drn_d;
    logic             busy_q, done_q, rd_en_q, clear_q, preload_q;
    logic             rd_vld_q;
    logic             accept_s;

    assign accept_s = (state_q == ST_IDLE) && start;

    // Next-state and datapath-register update logic for the sequencer.
    always_comb begin
        state_d  = state_q;
        k_len_d  = k_len_q;
        mode_d   = mode_q;
        rd_idx_d = K_W'(0);
        drn_d    = drn_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_CLEAR;
                    k_len_d = k_len;
                    mode_d  = mode_os;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                if (k_len_q == K_W'(0)) begin
                    state_d = ST_DONE;
                end else if (!mode_q) begin
                    state_d = ST_PRELOAD;
                end else begin
                    state_d = ST_FEED;
                end
            end
            ST_PRELOAD: begin
                state_d = ST_FEED;
            end
            ST_FEED: begin
                if (rd_idx_q == (k_len_q - K_W'(1))) begin
                    state_d = ST_DRAIN;
                    drn_d   = DRN_LOAD;
                end else begin
                    state_d  = ST_FEED;
                    rd_idx_d = rd_idx_q + K_W'(1);
                end
            end
            ST_DRAIN: begin
                if (drn_q == DRN_W'(0)) begin
                    state_d = ST_DONE;
                end else begin
                    drn_d = drn_q - DRN_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, latched operation parameters and counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            k_len_q  <= K_W'(0);
            mode_q   <= 1'b1;
            rd_idx_q <= K_W'(0);
            drn_q    <= DRN_W'(0);
        end else begin
            state_q  <= state_d;
            k_len_q  <= k_len_d;
            mode_q   <= mode_d;
            rd_idx_q <= rd_idx_d;
            drn_q    <= drn_d;
        end
    end

    // Registered control strobes decoded from the upcoming state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rd_en_q   <= 1'b0;
            clear_q   <= 1'b0;
            preload_q <= 1'b0;
            rd_vld_q  <= 1'b0;
        end else begin
            busy_q    <= (state_d != ST_IDLE);
            done_q    <= (state_d == ST_DONE);
            rd_en_q   <= (state_d == ST_FEED);
            clear_q   <= (state_d == ST_CLEAR);
            preload_q <= (state_d == ST_PRELOAD);
            rd_vld_q  <= rd_en_q;
        end
    end

    assign busy                 = busy_q;
    assign done                 = done_q;
    assign rd_en                = rd_en_q;
    assign rd_idx               = rd_idx_q;
    assign sa_clear             = clear_q;
    assign sa_output_stationary = mode_q;
    assign sa_preload_valid     = preload_q;

    // Left-edge skew: lane r is delayed r+1 cycles behind the buffer data.
    for (genvar r = 0; r < M; r++) begin : g_left
        sa_skew_line #(.DEPTH(r + 1)) u_line (
            .clk     (clk),
            .rst_n   (reset),
            .data_i  (a_rd_data[DW*r +: DW]),
            .valid_i (rd_vld_q),
            .data_o  (sa_in_left[DW*r +: DW])
        );
    end

    // Top-edge skew: lane c is delayed c+1 cycles behind the buffer data.
    for (genvar c = 0; c < N; c++) begin : g_top
        sa_skew_line #(.DEPTH(c + 1)) u_line (
            .clk     (clk),
            .rst_n   (reset),
            .data_i  (b_rd_data[DW*c +: DW]),
            .valid_i (rd_vld_q),
            .data_o  (sa_in_top[DW*c +: DW])
        );
    end

`ifdef SA_ARRAY_CTRL_PERF_EN
    logic [31:0] perf_q;

    // Busy-cycle counter: cleared on acceptance, saturates, holds when idle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_q <= 32'd0;
        end else if (accept_s) begin
            perf_q <= 32'd0;
        end else if ((state_q != ST_IDLE) && (perf_q != 32'hFFFF_FFFF)) begin
            perf_q <= perf_q + 32'd1;
        end else begin
            perf_q <= perf_q;
        end
    end

    assign perf_cycles = perf_q;
`else
    logic unused_accept_s;
    assign unused_accept_s = accept_s;
`endif

endmodule

// File: doc/sa_array_ctrl.md
# sa_array_ctrl

Sequencer for the M×N systolic array: accepts a start handshake with an inner dimension K and clears the array accumulators. It optionally strobes a weight preload, then reads K operand vectors from the A/B operand buffers and skews them diagonally onto the array's left and top edges. After the pipeline drain it pulses done. It sits between the operand buffers and the array, owning the array's reset, mode and preload controls.

## Interface
- M, 3, array rows (lanes on the left edge)
- N, 3, array columns (lanes on the top edge)
- K_W, 8, width of k_len and read index
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low
- start  in  1  request; accepted only in IDLE
- k_len  in  K_W  inner dimension K, sampled at acceptance
- mode_os  in  1  1 = output-stationary, 0 = weight-stationary; sampled at acceptance
- busy  out  1  high whenever state ≠ IDLE
- done  out  1  one-cycle completion pulse
- rd_en  out  1  operand read strobe (A and B buffers share it)
- rd_idx  out  K_W  k index of the current read
- a_rd_data  in  64*M  A column k, lane r = bits 64r+63:64r, valid the cycle after rd_en
- b_rd_data  in  64*N  B row k, lane c, same latency
- sa_in_left  out  64*M  skewed A to the array's left edge
- sa_in_top  out  64*N  skewed B to the array's top edge
- sa_clear  out  1  active-high accumulator clear to the array
- sa_output_stationary  out  1  registered mode to the array
- sa_preload_valid  out  1  preload strobe to the array

## Operation
- States: IDLE, CLEAR, PRELOAD, FEED, DRAIN, DONE.
- IDLE + start=1: latch k_len and mode_os, go to CLEAR. Start in any other state is ignored.
- CLEAR (1 cycle): sa_clear=1. Next state:
  - k_len=0: DONE.
  - mode_os=0: PRELOAD.
  - otherwise: FEED.
- PRELOAD (1 cycle): sa_preload_valid=1, then FEED.
- FEED (K cycles): rd_en=1, rd_idx counts 0..K-1, then DRAIN.
- DRAIN (M+N cycles, down-counter), then DONE.
- DONE (1 cycle): done=1, then IDLE.
- Skew:
  - Lane r of A passes through r+1 registers; lane c of B passes through c+1 registers.
  - A one-bit valid travels with the data. Lanes with no valid data drive 64'h0, so bubbles add nothing to the accumulators.
- sa_output_stationary updates only at acceptance and holds between operations.
- Reset (asynchronous assert, any state): state IDLE, all counters 0, all skew registers 0.
- Output reset values: every output is 0 except sa_output_stationary, which resets to 1.

## Timing
- Let S be the acceptance cycle, CLEAR runs at S+1, and F0 is the first FEED cycle.
  - Output-stationary: F0 = S+2.
  - Weight-stationary: PRELOAD at S+2, F0 = S+3.
- A[r][k] appears on sa_in_left lane r in cycle F0+k+r+2. B[k][c] appears on sa_in_top lane c in cycle F0+k+c+2.
- The last MAC, at PE(M-1,N-1), happens in cycle F0+K+M+N-1. done pulses at F0+K+M+N, and the array results are final in that cycle.
- k_len=0: done pulses at S+2, with no rd_en and no preload.
- A start held high during DONE is ignored. A new start is accepted in IDLE, at the earliest the cycle after DONE.

## Configuration
- SA_ARRAY_CTRL_PERF_EN
  - Defined: adds output perf_cycles [31:0]. It is cleared at acceptance, increments every busy cycle (saturating), and holds after done. Reset value 0.
  - Undefined: the port and counter are absent; all other behaviour is identical.

## Structure
- Package sa_pkg holds:
  - DW = 64.
  - The state enum typedef.
  - A ceil-log2 function for the drain counter width.
- Sub-module sa_skew_line: one delay line with parameter DEPTH, carrying 64-bit data plus a valid bit, with async active-low reset. It is instantiated M+N times, with DEPTH = lane index + 1.

## Test plan
- M=N=3, OS, K=4, A=all 1, B=all 2 -> done at S+12, rd_idx 0,1,2,3 at S+2..S+5, every PE accumulates 8.
- Same operands with mode_os=0 -> sa_preload_valid only at S+2, sa_output_stationary=0, done at S+13.
- k_len=0 -> sa_clear at S+1, done at S+2, rd_en never high, busy high for exactly 2 cycles.
- start pulsed during FEED and again during DONE -> both ignored, a single done, rd_idx sequence undisturbed.
- reset asserted mid-DRAIN -> immediately IDLE, sa_in_left/sa_in_top=0, no done. The next start runs cleanly to done at the nominal cycle.
- Skew check, K=1, A lanes 10/20/30 -> sa_in_left lanes nonzero only at F0+2, F0+3 and F0+4 respectively; zero in every other cycle.
